// File: rtl/rx_comma_align_ctrl.sv
// rtl/rx_comma_align_ctrl.sv - 8b/10b comma hunt, boundary verify and 10-bit word framing
// Hunts K28.1/5/7 commas in the serial stream, confirms a stable phase, then frames words while locked.
module rx_comma_align_ctrl #(
  parameter int ACQ_COMMAS    = 3,
  parameter int ERR_THRESH    = 4,
  parameter int TIMEOUT_WORDS = 16
) (
  input  logic       BitCLK,
  input  logic       Reset,
  input  logic       Serial,
  output logic [9:0] RxParallel_10,
  output logic       WordValid,
  output logic       Aligned,
  output logic       Realign,
  output logic [1:0] State
);
  localparam int AW = $clog2(ACQ_COMMAS + 1);
  localparam int MW = $clog2(ERR_THRESH + 1);
  localparam int GW = $clog2(TIMEOUT_WORDS + 1);
  localparam logic [AW-1:0] ACQ_N = AW'(ACQ_COMMAS);
  localparam logic [MW-1:0] MIS_N = MW'(ERR_THRESH);
  localparam logic [GW-1:0] GAP_N = GW'(TIMEOUT_WORDS);

  typedef enum logic [1:0] {
    S_HUNT   = 2'b00,
    S_VERIFY = 2'b01,
    S_LOCKED = 2'b10
  } state_t;

  state_t        r_state;
  logic [9:0]    r_sr;
  logic [9:0]    r_rx;
  logic [3:0]    r_ph;
  logic [AW-1:0] r_acq;
  logic [MW-1:0] r_mis;
  logic [GW-1:0] r_gap;
  logic          r_wv;
  logic          r_realign;

  logic          w_comma_hit;
  logic          w_boundary;
  logic [3:0]    w_ph_nx;
  logic [AW-1:0] w_acq_nx;
  logic [MW-1:0] w_mis_nx;
  logic [GW-1:0] w_gap_nx;

  // First-received bit sits in sr[0], so codes are written with bit a as the LSB.
  assign w_comma_hit = (r_sr == 10'h27C) || (r_sr == 10'h183) ||
                       (r_sr == 10'h17C) || (r_sr == 10'h283) ||
                       (r_sr == 10'h07C) || (r_sr == 10'h383);
  assign w_boundary  = (r_ph == 4'd9);
  assign w_ph_nx     = w_boundary ? 4'd0 : r_ph + 4'd1;
  assign w_acq_nx    = r_acq + AW'(1);
  assign w_mis_nx    = r_mis + MW'(1);
  assign w_gap_nx    = r_gap + GW'(1);

  assign RxParallel_10 = r_rx;
  assign WordValid     = r_wv;
  assign Realign       = r_realign;
  assign State         = r_state;
  assign Aligned       = (r_state == S_LOCKED);

  always_ff @(posedge BitCLK or posedge Reset) begin
    if (Reset) begin
      r_state   <= S_HUNT;
      r_sr      <= '0;
      r_rx      <= '0;
      r_ph      <= '0;
      r_acq     <= '0;
      r_mis     <= '0;
      r_gap     <= '0;
      r_wv      <= 1'b0;
      r_realign <= 1'b0;
    end else begin
      r_sr      <= {Serial, r_sr[9:1]};
      r_ph      <= w_ph_nx;
      r_wv      <= 1'b0;
      r_realign <= 1'b0;
      case (r_state)
        S_HUNT: begin
          if (w_comma_hit) begin
            r_ph      <= 4'd0;
            r_realign <= 1'b1;
            r_acq     <= AW'(1);
            r_gap     <= '0;
            r_state   <= S_VERIFY;
          end
        end
        S_VERIFY: begin
          if (w_boundary && w_comma_hit) begin
            r_acq <= w_acq_nx;
            r_gap <= '0;
            if (w_acq_nx == ACQ_N) begin
              r_state <= S_LOCKED;
              r_mis   <= '0;
              r_rx    <= r_sr;
              r_wv    <= 1'b1;
            end
          end else if (w_boundary) begin
            if (w_gap_nx == GAP_N) begin
              r_state <= S_HUNT;
              r_acq   <= '0;
              r_mis   <= '0;
              r_gap   <= '0;
            end else begin
              r_gap <= w_gap_nx;
            end
          end else if (w_comma_hit) begin
            r_ph      <= 4'd0;
            r_realign <= 1'b1;
            r_acq     <= AW'(1);
            r_gap     <= '0;
          end
        end
        S_LOCKED: begin
          // The word that times out is not strobed, so WordValid never outlives LOCKED.
          if (w_boundary && w_comma_hit) begin
            r_gap <= '0;
            r_mis <= '0;
            r_rx  <= r_sr;
            r_wv  <= 1'b1;
          end else if (w_boundary) begin
            if (w_gap_nx == GAP_N) begin
              r_state <= S_HUNT;
              r_acq   <= '0;
              r_mis   <= '0;
              r_gap   <= '0;
            end else begin
              r_gap <= w_gap_nx;
              r_rx  <= r_sr;
              r_wv  <= 1'b1;
            end
          end else if (w_comma_hit) begin
            if (w_mis_nx == MIS_N) begin
              r_state <= S_HUNT;
              r_acq   <= '0;
              r_mis   <= '0;
              r_gap   <= '0;
            end else begin
              r_mis <= w_mis_nx;
            end
          end
        end
        default: begin
          r_state <= S_HUNT;
          r_acq   <= '0;
          r_mis   <= '0;
          r_gap   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rx_comma_align_ctrl.sv
// tb/tb_rx_comma_align_ctrl.sv - directed vector bench for rx_comma_align_ctrl
// Words go out LSB first; o_* capture the outputs after the first bit of each word.
module tb_rx_comma_align_ctrl;
  localparam logic [9:0] Z   = 10'h000;
  localparam logic [9:0] K5N = 10'h17C;
  localparam logic [9:0] K5P = 10'h283;
  localparam logic [9:0] K1N = 10'h27C;
  localparam logic [9:0] K1P = 10'h183;
  localparam logic [9:0] K7N = 10'h07C;
  localparam logic [9:0] K7P = 10'h383;
  localparam logic [1:0] ST_HUNT = 2'b00;
  localparam logic [1:0] ST_VER  = 2'b01;
  localparam logic [1:0] ST_LOCK = 2'b10;

  typedef struct {
    logic [9:0] word;
    logic [1:0] st;
    logic       rl;
    logic       wv;
    logic [9:0] rx;
  } vec_t;

  logic       BitCLK = 1'b0;
  logic       Reset  = 1'b1;
  logic       Serial = 1'b0;
  logic [9:0] RxParallel_10;
  logic       WordValid;
  logic       Aligned;
  logic       Realign;
  logic [1:0] State;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [1:0] o_state;
  logic       o_realign, o_wv, o_aligned;
  logic [9:0] o_rx;
  int         o_wv_rest;
  vec_t       vecs [14];

  rx_comma_align_ctrl dut (
    .BitCLK(BitCLK), .Reset(Reset), .Serial(Serial),
    .RxParallel_10(RxParallel_10), .WordValid(WordValid),
    .Aligned(Aligned), .Realign(Realign), .State(State)
  );

  always #5 BitCLK = ~BitCLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick(input logic b);
    Serial = b;
    @(posedge BitCLK);
    #1;
  endtask

  task automatic send_bits(input logic [9:0] w, input int n);
    for (int i = 0; i < n; i++) tick(w[i]);
  endtask

  task automatic send_word(input logic [9:0] w);
    o_wv_rest = 0;
    for (int i = 0; i < 10; i++) begin
      tick(w[i]);
      if (i == 0) begin
        o_state   = State;
        o_realign = Realign;
        o_wv      = WordValid;
        o_rx      = RxParallel_10;
        o_aligned = Aligned;
      end else if (WordValid) begin
        o_wv_rest++;
      end
    end
  endtask

  task automatic expect_obs(input string tag, input logic [1:0] st, input logic rl,
                            input logic wv, input logic [9:0] rx);
    check({tag, ".state"},   32'(o_state),   32'(st));
    check({tag, ".aligned"}, 32'(o_aligned), 32'(st == ST_LOCK));
    check({tag, ".realign"}, 32'(o_realign), 32'(rl));
    check({tag, ".wvalid"},  32'(o_wv),      32'(wv));
    check({tag, ".rx"},      32'(o_rx),      32'(rx));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ".state"},   32'(State),         32'(ST_HUNT));
    check({tag, ".wvalid"},  32'(WordValid),     32'd0);
    check({tag, ".aligned"}, 32'(Aligned),       32'd0);
    check({tag, ".realign"}, 32'(Realign),       32'd0);
    check({tag, ".rx"},      32'(RxParallel_10), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run time limit 2000000 reached, expected finish earlier");
    $fatal(1);
  end

  initial begin
    int   viol;
    int   run;
    logic last;
    logic b;

    vecs[0]  = '{Z,   ST_HUNT, 1'b0, 1'b0, Z};
    vecs[1]  = '{Z,   ST_HUNT, 1'b0, 1'b0, Z};
    vecs[2]  = '{K5N, ST_HUNT, 1'b0, 1'b0, Z};
    vecs[3]  = '{K5N, ST_VER,  1'b1, 1'b0, Z};
    vecs[4]  = '{K5N, ST_VER,  1'b0, 1'b0, Z};
    vecs[5]  = '{Z,   ST_LOCK, 1'b0, 1'b1, K5N};
    vecs[6]  = '{K1N, ST_LOCK, 1'b0, 1'b1, Z};
    vecs[7]  = '{Z,   ST_LOCK, 1'b0, 1'b1, K1N};
    vecs[8]  = '{K7N, ST_LOCK, 1'b0, 1'b1, Z};
    vecs[9]  = '{K5P, ST_LOCK, 1'b0, 1'b1, K7N};
    vecs[10] = '{K1P, ST_LOCK, 1'b0, 1'b1, K5P};
    vecs[11] = '{K7P, ST_LOCK, 1'b0, 1'b1, K1P};
    vecs[12] = '{Z,   ST_LOCK, 1'b0, 1'b1, K7P};
    vecs[13] = '{Z,   ST_LOCK, 1'b0, 1'b1, Z};

    repeat (2) @(posedge BitCLK);
    #1;
    check_outputs_zero("reset");
    Reset = 1'b0;

    // Idle, three aligned K28.5, then every comma code framed while locked.
    for (int i = 0; i < 14; i++) begin
      send_word(vecs[i].word);
      expect_obs($sformatf("vec%0d", i), vecs[i].st, vecs[i].rl, vecs[i].wv, vecs[i].rx);
      check($sformatf("vec%0d.wv_mid", i), 32'(o_wv_rest), 32'd0);
    end

    // Timeout: 15 comma-free words survive, the 16th drops lock.
    send_word(K5N);
    for (int k = 1; k <= 15; k++) send_word(Z);
    send_word(K5N);
    expect_obs("t5.gap15", ST_LOCK, 1'b0, 1'b1, Z);
    send_word(Z);
    expect_obs("t5.comma", ST_LOCK, 1'b0, 1'b1, K5N);
    for (int k = 2; k <= 16; k++) send_word(Z);
    expect_obs("t5.z15", ST_LOCK, 1'b0, 1'b1, Z);
    send_word(Z);
    expect_obs("t5.z16", ST_HUNT, 1'b0, 1'b0, Z);

    // Second comma 3 bits early re-seeds the phase and restarts acquisition.
    send_word(K5N);
    tick(1'b0);
    check("t3.seed.realign", 32'(Realign), 32'd1);
    check("t3.seed.state",   32'(State),   32'(ST_VER));
    send_bits(Z, 6);
    send_word(K5N);
    send_word(K5N);
    expect_obs("t3.early", ST_VER, 1'b1, 1'b0, Z);
    send_word(K5N);
    expect_obs("t3.acq2", ST_VER, 1'b0, 1'b0, Z);
    send_word(Z);
    expect_obs("t3.lock", ST_LOCK, 1'b0, 1'b1, K5N);

    // Off-phase commas: three then an aligned one keeps lock; four drop it.
    for (int r = 0; r < 3; r++) begin
      send_bits(Z, 5);
      send_bits(K5N, 10);
      tick(1'b0);
      check($sformatf("t4a.off%0d.state", r), 32'(State), 32'(ST_LOCK));
      send_bits(Z, 4);
    end
    send_word(K5N);
    send_word(Z);
    expect_obs("t4a.aligned", ST_LOCK, 1'b0, 1'b1, K5N);
    for (int r = 0; r < 4; r++) begin
      send_bits(Z, 5);
      send_bits(K5N, 10);
      if (r == 3) check("t4b.pre.aligned", 32'(Aligned), 32'd1);
      tick(1'b0);
      check($sformatf("t4b.off%0d.state", r), 32'(State), (r == 3) ? 32'(ST_HUNT) : 32'(ST_LOCK));
      send_bits(Z, 4);
    end
    check("t4b.aligned", 32'(Aligned),       32'd0);
    check("t4b.wvalid",  32'(WordValid),     32'd0);
    check("t4b.rx_hold", 32'(RxParallel_10), 32'h380);

    // Relock, then reset mid-word must clear everything before the next edge.
    send_word(K5N);
    send_word(K5N);
    send_word(K5N);
    send_word(Z);
    expect_obs("relock", ST_LOCK, 1'b0, 1'b1, K5N);
    send_bits(Z, 4);
    Reset = 1'b1;
    #1;
    check_outputs_zero("t1.async");
    repeat (2) @(posedge BitCLK);
    #1;
    Reset = 1'b0;

    // Comma-free random bits: runs capped at 4 so no comma pattern can form.
    viol = 0;
    run  = 0;
    last = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      b = 1'($urandom_range(0, 1));
      if (run >= 4 && b == last) b = ~last;
      if (b == last) run++;
      else begin
        run  = 1;
        last = b;
      end
      tick(b);
      if (State != ST_HUNT || WordValid || Realign) viol++;
    end
    check("t6.violations", 32'(viol), 32'd0);
    check("t6.rx", 32'(RxParallel_10), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
